intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the Flags block and the control unit.
- Synchronises asynchronous external interrupt lines, detects rising edges, latches them as pending, and applies a mask.
- When the interrupt-enable flag from Flags (intr_out) is high, it raises a prioritised request to the control unit.
- It tracks the ISR until RETIE re-enables interrupts, so the control unit's intr_clr/intr_set into Flags bracket one serviced source at a time.

Parameters:
- NUM_SRC, 4: number of external interrupt sources, legal range 1..8.
- ID_W, 3: width of src_id. Must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_SRC  raw asynchronous interrupt lines; rising-edge sensitive.
- intr_en  in  1  interrupt-enable flag from the Flags block (its intr_out).
- mask_ld  in  1  loads mask_din into the mask register.
- mask_din  in  NUM_SRC  new mask value; 1 = source enabled.
- pend_clr  in  1  clears all pending bits.
- cu_ack  in  1  control unit is entering its interrupt cycle; single-cycle pulse.
- intr_req  out  1  interrupt request to the control unit.
- src_id  out  ID_W  index of the source being requested or serviced.
- pending  out  NUM_SRC  current pending vector, exposed on the input port mux.
- in_service  out  1  high while an ISR is active.

Behaviour:
- Reset (asynchronous, rst_n=0) clears all of the following:
  - synchroniser flops, edge-detect flops, pending and mask registers;
  - intr_req, in_service and src_id (all 0);
  - FSM state, which goes to IDLE.
- Synchroniser: two flops per source (s1, s2), plus a third flop s3 for edge detection. edge[i] = s2[i] & ~s3[i].
- Latency: irq_in[i] is first sampled high at edge k. pending[i] is visible after edge k+2. intr_req rises after edge k+3 if the request is eligible.
- Edge rules: a level held high produces exactly one edge. A pulse shorter than one clock period may be missed; that is permitted.
- Pending set: pending[i] sets on edge[i] regardless of mask and regardless of FSM state.
- Pending clear and precedence, highest first:
  - set by edge;
  - clear by pend_clr;
  - clear of the serviced bit on cu_ack.
  - So an edge on the serviced source in the ack cycle leaves the bit pending.
- Mask: mask_ld updates the mask on the next edge. mask_ld in the same cycle as the request decision uses the old mask.
- Eligibility: elig = pending & mask. The winner is the lowest-index set bit of elig (index 0 has highest priority).
- FSM states:
  - IDLE:
    - if intr_en=1 and elig!=0, go to REQ next cycle;
    - in the same edge, register src_id = winner and set intr_req=1.
  - REQ:
    - intr_req and src_id are held stable; priority is not re-arbitrated.
    - On cu_ack: clear pending[src_id], deassert intr_req, set in_service=1, go to WAIT_CLR.
    - If intr_en falls before the ack (a control-unit SEI/CLI race): drop intr_req, return to IDLE, leave pending untouched.
  - WAIT_CLR: wait for intr_en=0 (the control unit has issued intr_clr to Flags), then go to SERVICE. src_id is held.
  - SERVICE: on intr_en=1 (RETIE or SEI), clear in_service and go to IDLE. src_id is held until that exit.
- cu_ack outside REQ is ignored: no state change, no pending clear.
- Nesting is not supported: while in WAIT_CLR or SERVICE, new edges only accumulate in pending.
- Reset mid-operation (any state): outputs immediately take their reset values, and all pending bits are lost.
- Width rule: src_id is zero-extended from the winner index. Unused upper index values never appear.

Decomposition:
- Package intr_pkg holds:
  - the state_t enum {IDLE, REQ, WAIT_CLR, SERVICE}, 2 bits;
  - the constants NUM_SRC_DEF=4 and ID_W_DEF=3;
  - a priority-encode function returning the lowest set index.
- Sub-module irq_sync_edge:
  - one per source, generated NUM_SRC times;
  - ports clk, rst_n, async_in, edge_out;
  - contains s1/s2/s3.
- Pending, mask, arbitration and the FSM stay in intr_ctrl.

Test Plan:
- Reset and basic request: assert rst_n=0 for 2 cycles; set mask=4'b1111, intr_en=1; raise irq_in[2] at cycle 10.
  - pending=4'b0100 after cycle 12; intr_req=1 and src_id=2 after cycle 13.
  - cu_ack at cycle 15 gives pending=0, intr_req=0, in_service=1.
- Priority: with intr_en=0, raise irq_in[3] and irq_in[1] together, then set intr_en=1. Expect src_id=1. After ack, then intr_en 0 followed by 1, expect a second request with src_id=3.
- Masking: mask=4'b1110, irq_in[0] edge. Expect pending[0]=1 and intr_req stays 0. Then mask_ld with 4'b1111: intr_req=1 and src_id=0 two edges later.
- Edge during ack: the cycle cu_ack is asserted for src 2 coincides with edge[2]. Expect pending[2] to remain 1, and a re-request after RETIE.
- Enable race: in REQ, drop intr_en before cu_ack. Expect intr_req=0 next cycle, state IDLE, pending unchanged. Re-raising intr_en re-requests the same src_id.
- Async reset mid-SERVICE: with in_service=1, pulse rst_n low between clock edges. Expect in_service=0, pending=0 and mask=0 immediately, with no clock required.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// default sizing, and a lowest-index priority encoder.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CLR = 2'd2,
        SERVICE  = 2'd3
    } state_t;

    localparam int NUM_SRC_DEF = 4;
    localparam int ID_W_DEF    = 3;

    // Index 0 wins; scanning downward lets the lowest set bit overwrite last.
    function automatic logic [2:0] prio_enc(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = vec[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, with a third
// flop so a rising edge becomes a single-cycle pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain plus edge-detect delay stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= async_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign edge_out = s2_r & ~s3_r;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches synchronised rising edges as pending, masks
// and prioritises them, and brackets one serviced source until RETIE.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               intr_en,
    input  logic               mask_ld,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               pend_clr,
    input  logic               cu_ack,
    output logic               intr_req,
    output logic [ID_W-1:0]    src_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    logic [NUM_SRC-1:0] edge_s;
    logic [NUM_SRC-1:0] pend_r;
    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] elig_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [NUM_SRC-1:0] pend_nxt_s;
    logic [2:0]         win_s;
    state_t             state_r;
    state_t             next_state_s;
    logic               intr_req_r;
    logic               req_nxt_s;
    logic               in_service_r;
    logic               insvc_nxt_s;
    logic [ID_W-1:0]    src_id_r;
    logic [ID_W-1:0]    src_nxt_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (irq_in[g]),
            .edge_out (edge_s[g])
        );
    end

    assign elig_s = pend_r & mask_r;
    assign win_s  = prio_enc(8'(elig_s));

    // Serviced-bit clear: only an ack taken while requesting counts.
    always_comb begin
        ack_clr_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr_s[i] = (state_r == REQ) && cu_ack && (src_id_r == ID_W'(i));
        end
    end

    // Pending update; later assignments win, so edge set beats both clears.
    always_comb begin
        pend_nxt_s = pend_r & ~ack_clr_s;
        if (pend_clr) begin
            pend_nxt_s = {NUM_SRC{1'b0}};
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
        pend_nxt_s = pend_nxt_s | edge_s;
    end

    // Pending and mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {NUM_SRC{1'b0}};
            mask_r <= {NUM_SRC{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            mask_r <= mask_ld ? mask_din : mask_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; an ack in the same cycle as an enable drop is still taken.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:     if (intr_en && (elig_s != {NUM_SRC{1'b0}})) next_state_s = REQ;
                      else next_state_s = IDLE;
            REQ:      if (cu_ack) next_state_s = WAIT_CLR;
                      else if (!intr_en) next_state_s = IDLE;
                      else next_state_s = REQ;
            WAIT_CLR: if (!intr_en) next_state_s = SERVICE;
                      else next_state_s = WAIT_CLR;
            SERVICE:  if (intr_en) next_state_s = IDLE;
                      else next_state_s = SERVICE;
            default:  next_state_s = IDLE;
        endcase
    end

    // FSM outputs, computed as next values and registered below.
    always_comb begin
        req_nxt_s   = intr_req_r;
        insvc_nxt_s = in_service_r;
        src_nxt_s   = src_id_r;
        case (state_r)
            IDLE: begin
                if (intr_en && (elig_s != {NUM_SRC{1'b0}})) begin
                    req_nxt_s = 1'b1;
                    src_nxt_s = ID_W'(win_s);
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            REQ: begin
                if (cu_ack) begin
                    req_nxt_s   = 1'b0;
                    insvc_nxt_s = 1'b1;
                end else if (!intr_en) begin
                    req_nxt_s = 1'b0;
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            WAIT_CLR: insvc_nxt_s = 1'b1;
            SERVICE: begin
                if (intr_en) begin
                    insvc_nxt_s = 1'b0;
                end else begin
                    insvc_nxt_s = 1'b1;
                end
            end
            default: begin
                req_nxt_s   = 1'b0;
                insvc_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_req_r   <= 1'b0;
            in_service_r <= 1'b0;
            src_id_r     <= {ID_W{1'b0}};
        end else begin
            intr_req_r   <= req_nxt_s;
            in_service_r <= insvc_nxt_s;
            src_id_r     <= src_nxt_s;
        end
    end

    assign intr_req   = intr_req_r;
    assign in_service = in_service_r;
    assign src_id     = src_id_r;
    assign pending    = pend_r;

endmodule
